rvdff_skid_w34: RTL and testbench
=================================

// Module: rvdff_skid_w34
// PURPOSE
//  Two-entry registered skid buffer for a 34-bit payload with valid/ready handshakes on both sides.
//  It is the backpressure-aware counterpart of the free-running 34-bit capture flop.
//  Consumers use it where the downstream stage can stall, e.g. 32-bit data plus a 2-bit tag between decode and exu.
//  It breaks every combinational path between the input side and the output side, including ready.
//  It sustains one transfer per cycle with no bubbles.
// PARAMETERS
//  WIDTH   34   payload width in bits; legal range 1..64
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  rst        in   1      reset, synchronous, active-high
//  flush      in   1      synchronous flush; discards all buffered entries
//  in_valid   in   1      upstream offers in_data
//  in_ready   out  1      buffer can accept; registered (function of state only)
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds the oldest buffered entry
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  oldest entry; driven from a flop, no mux from in_data
//  occupancy  out  2      number of buffered entries (0..2)
// BEHAVIOUR
//  Transfers
//  - Accept: in_valid & in_ready at posedge.
//  - Drain:  out_valid & out_ready at posedge.
//  - Storage: head register (drives out_data) and skid register.
//  States
//  - EMPTY (occ 0): in_ready=1, out_valid=0.
//    - accept -> ONE; head<=in_data.
//  - ONE (occ 1): in_ready=1, out_valid=1.
//    - accept & drain -> ONE; head<=in_data (zero-bubble streaming).
//    - accept only -> FULL; skid<=in_data.
//    - drain only -> EMPTY.
//    - neither -> hold.
//  - FULL (occ 2): in_ready=0, out_valid=1.
//    - drain -> ONE; head<=skid.
//    - else -> hold.
//    - in_valid is ignored in FULL.
//  Ordering
//  - Strict FIFO order.
//  - Payload bits are passed unmodified; no width conversion.
//  Latency
//  - An entry accepted at edge N is visible on out_data in cycle N+1 at the earliest.
//  - in_ready reflects the state after edge N; there is no same-cycle ready-from-out_ready path.
//  Reset (rst=1 at posedge)
//  - State -> EMPTY; head and skid -> 0.
//  - Outputs after the edge: in_ready=1, out_valid=0, out_data=0, occupancy=0.
//  - Reset mid-stream discards all entries; rst has priority over flush and over all transfers.
//  Flush
//  - flush=1 at posedge: state -> EMPTY, head/skid -> 0.
//  - While flush=1: in_ready and out_valid are forced 0 combinationally, so no transfer completes in a flush cycle.
//  - Normal operation resumes the cycle after flush deasserts.
//  Sampling
//  - in_data is sampled only on accept.
//  - Holding in_valid high while in_ready=0 is legal; the offer is taken when ready returns.
//  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
// TESTING
//  - Reset: rst=1 for 2 cycles with in_valid=1, in_data=34'h3_DEAD_BEEF -> after release out_valid=0, occupancy=0, out_data=0, in_ready=1.
//  - Streaming: out_ready=1, send 8 beats 1..8 back-to-back -> out beats 1..8 on cycles 1..8 after first accept, occupancy stays 1, no bubbles.
//  - Stall/fill: out_ready=0, offer A,B,C -> A,B accepted, occupancy=2, in_ready=0, C held; raise out_ready -> out A,B,C in order.
//  - Flush when FULL: flush=1 with occupancy=2 -> next cycle occupancy=0, out_valid=0; no transfer completes in the flush cycle even with in_valid=out_ready=1.
//  - Reset mid-op: rst=1 while FULL with in_valid=1 -> after the edge the entries are dropped, state EMPTY, and the next accepted beat appears alone.
//  - Random: random valid/ready at 50%, 10k beats, scoreboard vs. a reference queue -> no loss, duplication or reordering; in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/rvdff_skid_w34.sv
// ---------------------------------------------------------------------------
// rvdff_skid_w34
//   Two-entry registered skid buffer with valid/ready handshakes on both sides.
//   Every combinational path between the input side and the output side is
//   broken by flops. It streams one beat per cycle with no bubbles. It absorbs
//   one extra beat in the skid register when the consumer stalls.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset; highest priority
//   flush      synchronous flush; drops buffered entries and blocks transfers
//   in_valid   upstream offers in_data
//   in_ready   buffer can accept (registered flag, gated only by flush)
//   in_data    upstream payload
//   out_valid  out_data holds the oldest buffered entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   oldest entry, driven directly from the head register
//   occupancy  number of buffered entries (0..2)
// ---------------------------------------------------------------------------
module rvdff_skid_w34 #(
   parameter int unsigned WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // State encoding equals the entry count, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_head_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             r_in_rdy;
   logic             r_out_vld;
   logic             w_accept;
   logic             w_drain;

   // Handshakes use the registered flags; flush blocks both sides.
   assign w_accept = in_valid  & r_in_rdy  & ~flush;
   assign w_drain  = out_ready & r_out_vld & ~flush;

   // Next-state and storage update.
   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_head_nxt  = '0;
         w_skid_nxt  = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_head_nxt  = in_data;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  // Streaming: the new beat replaces the one leaving.
                  w_head_nxt = in_data;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_skid_nxt  = in_data;
               end else if (w_drain) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  w_state_nxt = ST_ONE;
                  w_head_nxt  = r_skid;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // State, storage and handshake flags; ready/valid flags precomputed from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_EMPTY;
         r_head    <= '0;
         r_skid    <= '0;
         r_in_rdy  <= 1'b1;
         r_out_vld <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_head    <= w_head_nxt;
         r_skid    <= w_skid_nxt;
         r_in_rdy  <= (w_state_nxt != ST_FULL);
         r_out_vld <= (w_state_nxt != ST_EMPTY);
      end
   end

   assign in_ready  = r_in_rdy  & ~flush;
   assign out_valid = r_out_vld & ~flush;
   assign out_data  = r_head;
   assign occupancy = r_state;

endmodule

// File: tb/tb_rvdff_skid_w34.sv
// ---------------------------------------------------------------------------
// tb_rvdff_skid_w34
//   Directed scenarios plus a randomized stream for the 34-bit skid buffer.
//   The driver pushes each accepted beat into exp_q. The monitor pops exp_q
//   whenever a drain happens and compares it with out_data.
// ---------------------------------------------------------------------------
module tb_rvdff_skid_w34;
   localparam int unsigned W = 34;
   localparam int unsigned N_RAND = 10000;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   logic [W-1:0] exp_q[$];
   int           n_cmp;
   int           n_err;
   logic         prev_hold;
   logic         prev_rst;
   logic [W-1:0] prev_data;

   rvdff_skid_w34 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every drain must match the oldest outstanding beat; held outputs must be stable.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got %0h expected nothing", out_data);
         end else begin
            check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
      if (prev_hold && !prev_rst && out_valid)
         check("hold_stable", 64'(out_data), 64'(prev_data));
      prev_hold = out_valid && !out_ready;
      prev_rst  = rst;
      prev_data = out_data;
   end

   // Offer one beat and hold it until accepted; returns on the negedge before the accept edge.
   task automatic send(input logic [W-1:0] d);
      int  t;
      bit  done;
      t    = 0;
      done = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      while (!done) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            exp_q.push_back(d);
            done = 1;
         end else begin
            t++;
            if (t > 200) begin
               n_cmp++;
               n_err++;
               $display("FAIL send_timeout: got no accept expected accept of %0h", d);
               done = 1;
            end else begin
               @(posedge clk); #1;
            end
         end
      end
   endtask

   task automatic idle_in();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain_all();
      int t;
      t = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      int   sent;
      int   cyc;
      bit   pending;
      logic b;

      n_cmp     = 0;
      n_err     = 0;
      prev_hold = 1'b0;
      prev_rst  = 1'b1;
      prev_data = '0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 34'h3_DEAD_BEEF;
      out_ready = 1'b0;

      // Reset with an offer pending: nothing may be captured.
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);

      // Streaming: 8 back-to-back beats, occupancy stays 1.
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         send(W'(k));
         if (k > 1) begin
            check("stream_occ",  64'(occupancy), 64'd1);
            check("stream_data", 64'(out_data),  64'(k - 1));
         end
      end
      idle_in();
      @(negedge clk);
      check("stream_last", 64'(out_data),  64'd8);
      check("stream_occ8", 64'(occupancy), 64'd1);
      @(negedge clk);
      check("stream_empty", 64'(occupancy), 64'd0);

      // Stall/fill: A,B fill the buffer, C waits, then all drain in order.
      out_ready = 1'b0;
      send(34'h0_0000_00A0);
      send(34'h1_0000_00B0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 34'h2_0000_00C0;
      @(negedge clk);
      check("fill_occ",      64'(occupancy), 64'd2);
      check("fill_in_ready", 64'(in_ready),  64'd0);
      check("fill_head",     64'(out_data),  64'h0_0000_00A0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("fill_still_full", 64'(in_ready), 64'd0);
      send(34'h2_0000_00C0);
      idle_in();
      drain_all();

      // Flush while full, with both sides trying to transfer.
      out_ready = 1'b0;
      send(34'h1_1111_1111);
      send(34'h2_2222_2222);
      @(posedge clk); #1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 34'h3_3333_3333;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_in_ready",  64'(in_ready),  64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_occ",       64'(occupancy), 64'd0);
      check("flush_out_valid2",64'(out_valid), 64'd0);
      check("flush_out_data",  64'(out_data),  64'd0);
      check("flush_in_ready2", 64'(in_ready),  64'd1);

      // Reset while full with an offer pending; the next beat must appear alone.
      out_ready = 1'b0;
      send(34'h0_1234_5678);
      send(34'h1_8765_4321);
      @(posedge clk); #1;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 34'h2_AAAA_5555;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_occ", 64'(occupancy), 64'd0);
      check("mid_rst_ov",  64'(out_valid), 64'd0);
      out_ready = 1'b1;
      send(34'h3_0BAD_F00D);
      idle_in();
      @(negedge clk);
      check("mid_rst_occ1", 64'(occupancy), 64'd1);
      check("mid_rst_data", 64'(out_data),  64'h3_0BAD_F00D);
      @(negedge clk);
      check("mid_rst_occ0", 64'(occupancy), 64'd0);

      // Random valid/ready at 50%.
      sent    = 0;
      cyc     = 0;
      pending = 0;
      while ((sent < int'(N_RAND) || exp_q.size() != 0) && cyc < 80000) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(1));
         if (!pending && sent < int'(N_RAND) && $urandom_range(1) == 1) begin
            pending  = 1;
            in_valid = 1'b1;
            in_data  = {2'($urandom_range(3)), 32'($urandom)};
         end else if (!pending) begin
            in_valid = 1'b0;
         end
         if ((cyc % 997) == 0) begin
            b = in_ready;
            out_ready = ~out_ready;
            #1;
            check("in_ready_indep", 64'(in_ready), 64'(b));
            out_ready = ~out_ready;
         end
         @(negedge clk);
         if (pending && in_ready) begin
            exp_q.push_back(in_data);
            pending = 0;
            sent++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rand_sent",    64'(sent),         64'(N_RAND));
      check("rand_pending", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
